// File: rtl/eth_bridge_pkg.sv
// eth_bridge_pkg: shared definitions for the Ethernet port bridge.
//   MODE_*       encodings of the runtime forwarding mode
//   rx_state_t   per-RX-port frame tracking state
//   mode_sanitize folds the reserved encoding onto drop
package eth_bridge_pkg;

  localparam logic [1:0] MODE_LOOP = 2'd0;
  localparam logic [1:0] MODE_SWAP = 2'd1;
  localparam logic [1:0] MODE_DROP = 2'd2;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_PKT  = 1'b1
  } rx_state_t;

  // Encoding 3 is reserved and behaves exactly like drop, so it is stored as drop.
  function automatic logic [1:0] mode_sanitize(input logic [1:0] m);
    return (m == 2'd3) ? MODE_DROP : m;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry AXI4-Stream skid buffer (output register + skid register).
//   clk156, rst            clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake; in_ready is a register (= not full)
//   in_data/keep/last/user upstream beat
//   out_valid / out_ready  downstream handshake
//   out_data/keep/last/user downstream beat, held stable while stalled
module axis_skid_buf #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk156,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic              in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              out_user
);

  localparam int BW = DATA_W + KEEP_W + 2;

  logic [BW-1:0] in_beat, o_q, s_q;
  logic          o_vld, s_vld, rdy_q;
  logic          push, pop;
  logic          o_vld_n, s_vld_n, ld_o_skid, ld_o_in, ld_s;

  assign in_beat  = {in_user, in_last, in_keep, in_data};
  assign push     = in_valid && rdy_q;
  assign pop      = o_vld && out_ready;
  assign in_ready = rdy_q;

  // The output register refills whenever it is empty or being drained;
  // the skid register only ever holds the beat that arrived during a stall.
  always_comb begin
    o_vld_n   = o_vld;
    s_vld_n   = s_vld;
    ld_o_skid = 1'b0;
    ld_o_in   = 1'b0;
    ld_s      = 1'b0;
    if (pop || !o_vld) begin
      if (s_vld) begin
        ld_o_skid = 1'b1;
        o_vld_n   = 1'b1;
        s_vld_n   = push;
        ld_s      = push;
      end else begin
        o_vld_n = push;
        ld_o_in = push;
      end
    end else if (push) begin
      s_vld_n = 1'b1;
      ld_s    = 1'b1;
    end
  end

  always_ff @(posedge clk156) begin
    if (rst) begin
      o_q   <= '0;
      s_q   <= '0;
      o_vld <= 1'b0;
      s_vld <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      o_vld <= o_vld_n;
      s_vld <= s_vld_n;
      // Ready is computed from next occupancy so it never sees out_ready combinationally.
      rdy_q <= !(o_vld_n && s_vld_n);
      if (ld_o_skid)    o_q <= s_q;
      else if (ld_o_in) o_q <= in_beat;
      if (ld_s)         s_q <= in_beat;
    end
  end

  assign out_valid = o_vld;
  assign {out_user, out_last, out_keep, out_data} = o_q;

endmodule

// File: rtl/eth_port_bridge.sv
// eth_port_bridge: N-port AXI4-Stream bridge between 10G MACs (clk156 domain).
//   Forwards RX port s to TX port s (loopback), s^1 (swap) or nowhere (drop).
//   mode / active_mode        requested / applied mode; changes only at a global frame boundary
//   rx_t*                     per-port RX streams, port i at [i*W +: W]
//   tx_t*                     per-port TX streams, each behind a 2-entry skid buffer
//   stat_pkt/err/drop         per-RX-port saturating frame counters
// Optional feature macro: ETH_BRIDGE_STATS_EN (counters present; otherwise stat_* tied to 0).
module eth_port_bridge
  import eth_bridge_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                         clk156,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  output logic [1:0]                   active_mode,
  input  logic [NPORTS-1:0]            rx_tvalid,
  output logic [NPORTS-1:0]            rx_tready,
  input  logic [NPORTS*DATA_W-1:0]     rx_tdata,
  input  logic [NPORTS*(DATA_W/8)-1:0] rx_tkeep,
  input  logic [NPORTS-1:0]            rx_tlast,
  input  logic [NPORTS-1:0]            rx_tuser,
  output logic [NPORTS-1:0]            tx_tvalid,
  input  logic [NPORTS-1:0]            tx_tready,
  output logic [NPORTS*DATA_W-1:0]     tx_tdata,
  output logic [NPORTS*(DATA_W/8)-1:0] tx_tkeep,
  output logic [NPORTS-1:0]            tx_tlast,
  output logic [NPORTS-1:0]            tx_tuser,
  output logic [NPORTS*CNT_W-1:0]      stat_pkt,
  output logic [NPORTS*CNT_W-1:0]      stat_err,
  output logic [NPORTS*CNT_W-1:0]      stat_drop
);

  localparam int KEEP_W = DATA_W / 8;

  if ((NPORTS % 2) != 0 || NPORTS < 2) begin : g_bad_nports
    $error("eth_port_bridge: NPORTS must be a positive even number");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("eth_port_bridge: DATA_W must be a multiple of 8");
  end

  logic [NPORTS-1:0][DATA_W-1:0] rxd, txd;
  logic [NPORTS-1:0][KEEP_W-1:0] rxk, txk;

  assign rxd      = rx_tdata;
  assign rxk      = rx_tkeep;
  assign tx_tdata = txd;
  assign tx_tkeep = txk;

  logic [1:0]               mode_q;
  logic                     run_q;
  rx_state_t [NPORTS-1:0]   st;
  logic                     fwd, swap, all_idle;
  logic [NPORTS-1:0]        acc, buf_rdy;

  assign fwd         = (mode_q == MODE_LOOP) || (mode_q == MODE_SWAP);
  assign swap        = (mode_q == MODE_SWAP);
  assign acc         = rx_tvalid & rx_tready;
  assign active_mode = mode_q;

  always_comb begin
    all_idle = 1'b1;
    for (int i = 0; i < NPORTS; i++)
      if (st[i] != RX_IDLE) all_idle = 1'b0;
  end

  // Frame tracking and mode latch. The mode only moves when no port is inside a
  // frame and nothing is accepted this cycle, so the routing never changes mid-frame.
  // run_q gives the drop-mode ready its low-in-reset behaviour.
  always_ff @(posedge clk156) begin
    if (rst) begin
      mode_q <= MODE_LOOP;
      run_q  <= 1'b0;
      for (int i = 0; i < NPORTS; i++) st[i] <= RX_IDLE;
    end else begin
      run_q <= 1'b1;
      for (int i = 0; i < NPORTS; i++)
        if (acc[i]) st[i] <= rx_tlast[i] ? RX_IDLE : RX_PKT;
      if (all_idle && (acc == '0)) mode_q <= mode_sanitize(mode);
    end
  end

  // Destination d is fed by source d (loopback) or d^1 (swap); the pairing is a
  // bijection, so each buffer has exactly one possible source.
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    localparam int PAIR = g ^ 1;
    logic in_valid;

    assign in_valid     = fwd && (swap ? rx_tvalid[PAIR] : rx_tvalid[g]);
    assign rx_tready[g] = fwd ? (swap ? buf_rdy[PAIR] : buf_rdy[g]) : run_q;

    axis_skid_buf #(
      .DATA_W(DATA_W),
      .KEEP_W(KEEP_W)
    ) u_buf (
      .clk156    (clk156),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (buf_rdy[g]),
      .in_data   (swap ? rxd[PAIR] : rxd[g]),
      .in_keep   (swap ? rxk[PAIR] : rxk[g]),
      .in_last   (swap ? rx_tlast[PAIR] : rx_tlast[g]),
      .in_user   (swap ? rx_tuser[PAIR] : rx_tuser[g]),
      .out_valid (tx_tvalid[g]),
      .out_ready (tx_tready[g]),
      .out_data  (txd[g]),
      .out_keep  (txk[g]),
      .out_last  (tx_tlast[g]),
      .out_user  (tx_tuser[g])
    );
  end

`ifdef ETH_BRIDGE_STATS_EN
  logic [NPORTS-1:0][CNT_W-1:0] pkt_q, err_q, drop_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk156) begin
    if (rst) begin
      pkt_q  <= '0;
      err_q  <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (acc[i] && rx_tlast[i]) begin
          pkt_q[i] <= sat_inc(pkt_q[i]);
          if (rx_tuser[i]) err_q[i]  <= sat_inc(err_q[i]);
          if (!fwd)        drop_q[i] <= sat_inc(drop_q[i]);
        end
      end
    end
  end

  assign stat_pkt  = pkt_q;
  assign stat_err  = err_q;
  assign stat_drop = drop_q;
`else
  assign stat_pkt  = '0;
  assign stat_err  = '0;
  assign stat_drop = '0;
`endif

endmodule

// File: tb/tb_eth_port_bridge.sv
module tb_eth_port_bridge;
  import eth_bridge_pkg::*;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;
  localparam int BW = DW + KW + 2;

  logic              clk156;
  logic              rst;
  logic [1:0]        mode;
  logic [1:0]        active_mode;
  logic [NP-1:0]     rx_tvalid, rx_tready, rx_tlast, rx_tuser;
  logic [NP*DW-1:0]  rx_tdata, tx_tdata;
  logic [NP*KW-1:0]  rx_tkeep, tx_tkeep;
  logic [NP-1:0]     tx_tvalid, tx_tready, tx_tlast, tx_tuser;
  logic [NP*CW-1:0]  stat_pkt, stat_err, stat_drop;

  eth_port_bridge #(.NPORTS(NP), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk156(clk156), .rst(rst), .mode(mode), .active_mode(active_mode),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
    .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
    .stat_pkt(stat_pkt), .stat_err(stat_err), .stat_drop(stat_drop)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [BW-1:0] exp_q [NP][$];
  int checks;
  int errors;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // dest < 0 means the beat must be discarded.
  task automatic send(input int p, input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic u, input int dest);
    bit ok;
    ok = 1'b0;
    if (dest >= 0) exp_q[dest].push_back({u, l, k, d});
    rx_tvalid[p] = 1'b1;
    rx_tdata[p*DW +: DW] = d;
    rx_tkeep[p*KW +: KW] = k;
    rx_tlast[p] = l;
    rx_tuser[p] = u;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk156);
      ok = rx_tready[p];
      @(posedge clk156);
      #1;
    end
    rx_tvalid[p] = 1'b0;
    if (!ok) chk($sformatf("send_timeout_p%0d", p), 128'(ok), 128'd1);
  endtask

  task automatic wait_mode(input logic [1:0] m, input string name);
    for (int i = 0; i < 20 && active_mode != m; i++) @(negedge clk156);
    chk(name, 128'(active_mode), 128'(m));
    @(posedge clk156);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mode = MODE_LOOP;
    rx_tvalid = '0; rx_tdata = '0; rx_tkeep = '0; rx_tlast = '0; rx_tuser = '0;
    tx_tready = '0;

    // Scoreboard monitor: every TX handshake pops the next expected beat of that port.
    fork
      forever begin
        @(negedge clk156);
        for (int p = 0; p < NP; p++) begin
          if (tx_tvalid[p] && tx_tready[p]) begin
            logic [BW-1:0] beat, e;
            beat = {tx_tuser[p], tx_tlast[p], tx_tkeep[p*KW +: KW], tx_tdata[p*DW +: DW]};
            if (exp_q[p].size() == 0) begin
              chk($sformatf("tx_unexpected_p%0d", p), 128'(beat), 128'd0);
            end else begin
              e = exp_q[p].pop_front();
              chk($sformatf("tx_beat_p%0d", p), 128'(beat), 128'(e));
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk156);
    @(negedge clk156);
    chk("rst_tx_valid", 128'(tx_tvalid), 128'd0);
    chk("rst_rx_ready", 128'(rx_tready), 128'd0);
    chk("rst_active_mode", 128'(active_mode), 128'd0);
    chk("rst_stat_pkt", 128'(stat_pkt), 128'd0);
    @(posedge clk156); #1;
    rst = 1'b0;
    tx_tready = '1;
    @(posedge clk156);
    @(negedge clk156);
    chk("rx_ready_after_rst", 128'(rx_tready), 128'hF);
    @(posedge clk156); #1;

    // 1: loopback single beat on port 2, visible exactly one cycle after acceptance
    @(negedge clk156);
    chk("t1_idle_before", 128'(tx_tvalid), 128'd0);
    @(posedge clk156); #1;
    send(2, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b0, 2);
    @(negedge clk156);
    chk("t1_tx_valid", 128'(tx_tvalid), 128'b0100);
    chk("t1_tx_data", 128'(tx_tdata[2*DW +: DW]), 128'h0123456789ABCDEF);
    @(posedge clk156); #1;

    // 2: 8-beat frame on port 0 with a 5-cycle TX stall
    fork
      begin
        for (int b = 0; b < 8; b++)
          send(0, 64'h1000 + 64'(b), (b == 7) ? 8'h0F : 8'hFF, b == 7, 1'b0, 0);
      end
      begin
        repeat (3) @(posedge clk156);
        #1;
        tx_tready[0] = 1'b0;
        @(negedge clk156);
        chk("t2_rdy_one_held", 128'(rx_tready[0]), 128'd1);
        @(negedge clk156);
        chk("t2_rdy_full", 128'(rx_tready[0]), 128'd0);
        repeat (4) @(posedge clk156);
        #1;
        tx_tready[0] = 1'b1;
      end
    join
    repeat (3) @(posedge clk156);
    #1;
    chk("t2_drained", 128'(exp_q[0].size()), 128'd0);

    // 3: swap requested while port 1 is mid-frame
    send(1, 64'hAAAA_0001, 8'hFF, 1'b0, 1'b0, 1);
    mode = MODE_SWAP;
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    chk("t3_mode_deferred", 128'(active_mode), 128'd0);
    @(posedge clk156); #1;
    send(1, 64'hAAAA_0002, 8'h03, 1'b1, 1'b0, 1);
    @(negedge clk156);
    chk("t3_mode_at_tlast", 128'(active_mode), 128'd0);
    @(posedge clk156);
    @(negedge clk156);
    chk("t3_mode_swapped", 128'(active_mode), 128'd1);
    @(posedge clk156); #1;
    send(0, 64'hBBBB_0000, 8'hFF, 1'b1, 1'b0, 1);
    send(1, 64'hCCCC_0001, 8'h01, 1'b1, 1'b0, 0);
    repeat (3) @(posedge clk156);
    #1;

    // 4: drop mode, 3 frames on port 3, last one bad
    mode = MODE_DROP;
    wait_mode(MODE_DROP, "t4_mode_drop");
    @(negedge clk156);
    chk("t4_rdy_all", 128'(rx_tready), 128'hF);
    @(posedge clk156); #1;
    send(3, 64'hD0, 8'hFF, 1'b0, 1'b0, -1);
    send(3, 64'hD1, 8'hFF, 1'b1, 1'b0, -1);
    send(3, 64'hD2, 8'hFF, 1'b1, 1'b0, -1);
    send(3, 64'hD3, 8'h0F, 1'b1, 1'b1, -1);
    repeat (2) @(posedge clk156);
    @(negedge clk156);
    chk("t4_no_tx", 128'(tx_tvalid), 128'd0);
`ifdef ETH_BRIDGE_STATS_EN
    chk("t4_stat_drop3", 128'(stat_drop[3*CW +: CW]), 128'd3);
    chk("t4_stat_pkt3", 128'(stat_pkt[3*CW +: CW]), 128'd3);
    chk("t4_stat_err3", 128'(stat_err[3*CW +: CW]), 128'd1);
`else
    chk("t4_stat_off", 128'({stat_pkt, stat_err, stat_drop}), 128'd0);
`endif
    @(posedge clk156); #1;

    // 6: counter saturation on port 0 (already 2 frames counted)
    for (int f = 0; f < 12; f++) send(0, 64'hE000 + 64'(f), 8'hFF, 1'b1, 1'b0, -1);
    @(negedge clk156);
`ifdef ETH_BRIDGE_STATS_EN
    chk("t6_pkt0_14", 128'(stat_pkt[0 +: CW]), 128'hE);
`endif
    @(posedge clk156); #1;
    for (int f = 0; f < 5; f++) send(0, 64'hE100 + 64'(f), 8'hFF, 1'b1, 1'b0, -1);
    @(negedge clk156);
`ifdef ETH_BRIDGE_STATS_EN
    chk("t6_pkt0_sat", 128'(stat_pkt[0 +: CW]), 128'hF);
    chk("t6_drop0_sat", 128'(stat_drop[0 +: CW]), 128'hF);
    chk("t6_err0", 128'(stat_err[0 +: CW]), 128'd0);
`else
    chk("t6_stat_off", 128'(stat_pkt), 128'd0);
`endif
    @(posedge clk156); #1;

    // 5: reset mid-frame with two beats buffered on port 1
    mode = MODE_LOOP;
    wait_mode(MODE_LOOP, "t5_mode_loop");
    tx_tready[1] = 1'b0;
    send(1, 64'hF0, 8'hFF, 1'b0, 1'b0, 1);
    send(1, 64'hF1, 8'hFF, 1'b0, 1'b0, 1);
    @(negedge clk156);
    chk("t5_full", 128'(rx_tready[1]), 128'd0);
    @(posedge clk156); #1;
    rst = 1'b1;
    mode = MODE_SWAP;
    exp_q[1].delete();
    @(posedge clk156); #1;
    rst = 1'b0;
    @(negedge clk156);
    chk("t5_tx_valid", 128'(tx_tvalid), 128'd0);
    chk("t5_tx_data1", 128'(tx_tdata[DW +: DW]), 128'd0);
    chk("t5_rdy_in_rst", 128'(rx_tready), 128'd0);
    chk("t5_active_mode", 128'(active_mode), 128'd0);
    chk("t5_stat_clr", 128'({stat_pkt, stat_err, stat_drop}), 128'd0);
    @(posedge clk156); #1;
    tx_tready[1] = 1'b1;
    @(negedge clk156);
    chk("t5_rdy_after", 128'(rx_tready), 128'hF);
    chk("t5_fsm_idle", 128'(active_mode), 128'd1);
    repeat (3) @(posedge clk156);
    #1;
    send(0, 64'h5A5A, 8'h3F, 1'b1, 1'b1, 1);
    repeat (4) @(posedge clk156);
    @(negedge clk156);

    for (int p = 0; p < NP; p++)
      chk($sformatf("end_queue_empty_p%0d", p), 128'(exp_q[p].size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
